// File: rtl/dp_op_sequencer.sv
// dp_op_sequencer: command-level controller for the nibble-serial FSM datapath.
// One command = full-width operands + op_val program. The sequencer starts the
// datapath, streams operands in nibble by nibble, plays the program, steers the
// datapath into OUTPUT and collects the 16 result nibbles into one word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a command (cmd_ready high once settled)
// START   | dp_start high until the datapath reports INPUT (9)
// LOAD    | dp_input_enable high, one operand nibble per cycle
// RUN     | play prog[0..len-1], one step per datapath compute cycle
// DRAIN   | route table steers the datapath through S4 into OUTPUT
// COLLECT | capture output nibbles until all 16 are in
// RESP    | result offered, held until rsp_ready
module dp_op_sequencer #(
    parameter int N          = 64,
    parameter int N_width    = 4,
    parameter int PROG_DEPTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [N-1:0]            cmd_a,
    input  logic [N-1:0]            cmd_b,
    input  logic [2*PROG_DEPTH-1:0] cmd_prog,
    input  logic [3:0]              cmd_len,
    output logic                    dp_start,
    output logic                    dp_input_enable,
    output logic [N_width-1:0]      dp_a,
    output logic [N_width-1:0]      dp_b,
    output logic [1:0]              dp_op_val,
    input  logic [3:0]              dp_state,
    input  logic                    dp_output_valid,
    input  logic [N_width-1:0]      dp_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [N-1:0]            rsp_result,
    output logic                    rsp_error,
    output logic                    busy
);

    localparam int NIB  = N / N_width;
    localparam int IW   = $clog2(NIB);
    localparam int PIW  = $clog2(PROG_DEPTH);
    localparam int WDW  = $clog2(TIMEOUT);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NIB - 1);
    localparam logic [3:0]     LEN_MAX  = 4'(PROG_DEPTH);
    localparam logic [WDW-1:0] WD_LOAD  = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, START, LOAD, RUN, DRAIN, COLLECT, RESP
    } state_t;

    state_t                         st;
    logic [NIB-1:0][N_width-1:0]    a_q, b_q, res_q;
    logic [PROG_DEPTH-1:0][1:0]     prog_q;
    logic [3:0]                     len_q, pc;
    logic [IW-1:0]                  idx, cidx;
    logic [WDW-1:0]                 wd;
    logic                           active, capture;
    logic [IW-1:0]                  idx_nxt;
    logic [3:0]                     pc_nxt;

    // Drain routing: every compute state funnels to S4, S4 exits to OUTPUT.
    function automatic logic [1:0] route(input logic [3:0] s);
        case (s)
            4'd0, 4'd1: route = 2'd2;
            4'd4:       route = 2'd1;
            default:    route = 2'd0;
        endcase
    endfunction

    assign rsp_result = res_q;
    assign active     = (st != IDLE) && (st != RESP);
    assign idx_nxt    = idx + 1'b1;
    assign pc_nxt     = pc + 1'b1;
    assign capture    = dp_output_valid && ((st == COLLECT) || (st == DRAIN && dp_state == 4'd10));

    // op_val must follow the datapath state of the current cycle, so it is decoded, not registered.
    always_comb begin
        dp_op_val = 2'b00;
        if (st == RUN && dp_state < 4'd8 && pc < len_q)
            dp_op_val = prog_q[pc[PIW-1:0]];
        else if (st == DRAIN && dp_state < 4'd8)
            dp_op_val = route(dp_state);
    end

    // Sequencer FSM with registered handshake/datapath outputs and a per-state watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st              <= IDLE;
            cmd_ready       <= 1'b0;
            busy            <= 1'b0;
            dp_start        <= 1'b0;
            dp_input_enable <= 1'b0;
            dp_a            <= '0;
            dp_b            <= '0;
            rsp_valid       <= 1'b0;
            rsp_error       <= 1'b0;
            a_q             <= '0;
            b_q             <= '0;
            prog_q          <= '0;
            len_q           <= '0;
            pc              <= '0;
            idx             <= '0;
            cidx            <= '0;
            res_q           <= '0;
            wd              <= '0;
        end else begin
            if (wd != '0)
                wd <= wd - 1'b1;
            if (active && wd == '0) begin
                st              <= RESP;
                rsp_valid       <= 1'b1;
                rsp_error       <= 1'b1;
                dp_start        <= 1'b0;
                dp_input_enable <= 1'b0;
                dp_a            <= '0;
                dp_b            <= '0;
                wd              <= WD_LOAD;
            end else begin
                case (st)
                    IDLE: begin
                        if (cmd_valid && cmd_ready) begin
                            a_q       <= cmd_a;
                            b_q       <= cmd_b;
                            prog_q    <= cmd_prog;
                            len_q     <= (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
                            res_q     <= '0;
                            cidx      <= '0;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            dp_start  <= 1'b1;
                            st        <= START;
                            wd        <= WD_LOAD;
                        end else begin
                            cmd_ready <= 1'b1;
                        end
                    end
                    START: begin
                        if (dp_state == 4'd9) begin
                            dp_start        <= 1'b0;
                            dp_input_enable <= 1'b1;
                            dp_a            <= a_q[0];
                            dp_b            <= b_q[0];
                            idx             <= '0;
                            st              <= LOAD;
                            wd              <= WD_LOAD;
                        end
                    end
                    LOAD: begin
                        if (idx == IDX_LAST) begin
                            dp_input_enable <= 1'b0;
                            dp_a            <= '0;
                            dp_b            <= '0;
                            pc              <= '0;
                            st              <= RUN;
                            wd              <= WD_LOAD;
                        end else begin
                            idx  <= idx_nxt;
                            dp_a <= a_q[idx_nxt];
                            dp_b <= b_q[idx_nxt];
                        end
                    end
                    RUN: begin
                        // The last program step and the hand-over to DRAIN share a cycle.
                        if (pc == len_q) begin
                            st <= DRAIN;
                            wd <= WD_LOAD;
                        end else if (dp_state < 4'd8) begin
                            pc <= pc_nxt;
                            if (pc_nxt == len_q) begin
                                st <= DRAIN;
                                wd <= WD_LOAD;
                            end
                        end
                    end
                    DRAIN, COLLECT: begin
                        if (st == DRAIN && dp_state == 4'd10) begin
                            st <= COLLECT;
                            wd <= WD_LOAD;
                        end
                        if (capture) begin
                            res_q[cidx] <= dp_out;
                            cidx        <= cidx + 1'b1;
                            if (cidx == IDX_LAST) begin
                                rsp_valid <= 1'b1;
                                st        <= RESP;
                                wd        <= WD_LOAD;
                            end
                        end
                    end
                    RESP: begin
                        if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            rsp_error <= 1'b0;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            st        <= IDLE;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dp_op_sequencer.sv
// Bench for dp_op_sequencer. A small behavioural datapath stub answers the
// sequencer: it assembles the operands from the nibble stream, walks a fixed
// state graph driven by op_val and returns A if S1 was visited, else A|B.
module tb_dp_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_a = '0;
    logic [63:0] cmd_b = '0;
    logic [15:0] cmd_prog = '0;
    logic [3:0]  cmd_len = '0;
    logic        dp_start, dp_input_enable;
    logic [3:0]  dp_a, dp_b;
    logic [1:0]  dp_op_val;
    logic [3:0]  dp_state;
    logic        dp_output_valid;
    logic [3:0]  dp_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_result;
    logic        rsp_error;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int s0hold = 0;
    int actcnt = 0;
    logic stub_hang = 1'b0;

    dp_op_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_prog(cmd_prog), .cmd_len(cmd_len),
        .dp_start(dp_start), .dp_input_enable(dp_input_enable),
        .dp_a(dp_a), .dp_b(dp_b), .dp_op_val(dp_op_val),
        .dp_state(dp_state), .dp_output_valid(dp_output_valid), .dp_out(dp_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath stub
    logic [3:0]  ds, icnt, ocnt;
    logic [63:0] sa, sb, sres;
    logic        vis1;
    assign dp_state        = ds;
    assign dp_output_valid = (ds == 4'd10);
    assign sres            = vis1 ? sa : (sa | sb);
    assign dp_out          = sres[ocnt*4 +: 4];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ds <= 4'd8; icnt <= '0; ocnt <= '0; sa <= '0; sb <= '0; vis1 <= 1'b0;
        end else begin
            case (ds)
                4'd8: if (dp_start && !stub_hang) begin ds <= 4'd9; icnt <= '0; vis1 <= 1'b0; end
                4'd9: if (dp_input_enable) begin
                    sa[icnt*4 +: 4] <= dp_a;
                    sb[icnt*4 +: 4] <= dp_b;
                    icnt <= icnt + 1'b1;
                    if (icnt == 4'd15) ds <= 4'd0;
                end
                4'd10: begin ocnt <= ocnt + 1'b1; if (ocnt == 4'd15) ds <= 4'd8; end
                4'd0: case (dp_op_val)
                    2'd1: ds <= 4'd3;
                    2'd2: ds <= 4'd4;
                    2'd3: begin ds <= 4'd1; vis1 <= 1'b1; end
                    default: ;
                endcase
                4'd1: if (dp_op_val == 2'd1) ds <= 4'd7; else if (dp_op_val == 2'd2) ds <= 4'd5;
                4'd2: if (dp_op_val == 2'd0) ds <= 4'd6;
                4'd3: if (dp_op_val == 2'd0) ds <= 4'd2;
                4'd4: if (dp_op_val == 2'd1) begin ds <= 4'd10; ocnt <= '0; end
                4'd5, 4'd6, 4'd7: if (dp_op_val == 2'd0) ds <= (ds == 4'd5) ? 4'd4 : 4'd5;
                default: ;
            endcase
        end
    end

    // Observers: RUN/idle cycles spent holding S0, and active cycles before a response.
    always @(negedge clk) begin
        if (busy && dp_state == 4'd0 && dp_op_val == 2'd0) s0hold <= s0hold + 1;
        if (busy && !rsp_valid) actcnt <= actcnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [63:0] a, input logic [63:0] b, input logic [15:0] p,
                          input logic [3:0] l, output logic [63:0] r, output logic e,
                          output logic ok);
        int t;
        r = '0; e = 1'b0; ok = 1'b0;
        cmd_a = a; cmd_b = b; cmd_prog = p; cmd_len = l;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 300) begin @(negedge clk); t++; end
        ok = rsp_valid; r = rsp_result; e = rsp_error;
    endtask

    typedef struct {
        logic [63:0] a, b;
        logic [15:0] prog;
        logic [3:0]  len;
        logic [63:0] exp_r;
        logic        exp_e;
        int          exp_s0;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [63:0] r;
        logic e, ok;
        int s0a, act0, t;

        vecs[0] = '{64'h5, 64'h3, 16'h0000, 4'd0,  64'h7, 1'b0, 1};
        vecs[1] = '{64'h5, 64'h3, 16'h0003, 4'd1,  64'h5, 1'b0, 0};
        vecs[2] = '{64'h5, 64'h3, 16'h0000, 4'd15, 64'h7, 1'b0, 8};
        vecs[3] = '{64'h0123456789ABCDEF, 64'hF000000000000000, 16'h0000, 4'd0,
                    64'hF123456789ABCDEF, 1'b0, 1};
        vecs[4] = '{64'h0123456789ABCDEF, 64'hF000000000000000, 16'h0001, 4'd1,
                    64'hF123456789ABCDEF, 1'b0, 0};
        vecs[5] = '{64'h0123456789ABCDEF, 64'hF000000000000000, 16'h0007, 4'd2,
                    64'h0123456789ABCDEF, 1'b0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {cmd_ready, busy, dp_start, dp_input_enable, rsp_valid, rsp_error}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1'b1);

        // Table-driven commands
        for (int i = 0; i < 6; i++) begin
            s0a = s0hold;
            do_cmd(vecs[i].a, vecs[i].b, vecs[i].prog, vecs[i].len, r, e, ok);
            chk($sformatf("v%0d_rsp_seen", i), ok, 1'b1);
            chk($sformatf("v%0d_result", i), r, vecs[i].exp_r);
            chk($sformatf("v%0d_error", i), e, vecs[i].exp_e);
            chk($sformatf("v%0d_s0_hold", i), 64'(s0hold - s0a), 64'(vecs[i].exp_s0));
            @(negedge clk);
            chk($sformatf("v%0d_idle_after", i), {busy, rsp_valid, cmd_ready}, 64'b001);
        end

        // Back-pressure on the response while commands are offered
        rsp_ready = 1'b0;
        do_cmd(64'h5, 64'h3, 16'h0000, 4'd0, r, e, ok);
        chk("hold_rsp_seen", ok, 1'b1);
        cmd_a = 64'h5; cmd_b = 64'h3; cmd_prog = 16'h0003; cmd_len = 4'd1;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = (i % 2 == 0);
            @(negedge clk);
            chk($sformatf("hold_c%0d", i), {rsp_valid, cmd_ready, busy, rsp_result},
                {1'b1, 1'b0, 1'b1, 64'h7});
        end
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_handshake", {busy, rsp_valid, cmd_ready}, 64'b001);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("hold_accept_after_idle", {busy, cmd_ready}, 64'b10);
        t = 0;
        while (!rsp_valid && t < 300) begin @(negedge clk); t++; end
        chk("hold_next_result", {rsp_valid, rsp_result}, {1'b1, 64'h5});
        @(negedge clk);

        // Reset in the middle of the operand load
        do_cmd_start: begin
            cmd_a = 64'h5; cmd_b = 64'h3; cmd_prog = '0; cmd_len = 4'd0;
            cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            t = 0;
            while (!dp_input_enable && t < 50) begin @(negedge clk); t++; end
            chk("load_reached", dp_input_enable, 1'b1);
            repeat (7) @(negedge clk);
            rst = 1'b0;
            #1;
            chk("mid_reset_outputs",
                {cmd_ready, busy, dp_start, dp_input_enable, dp_a, dp_b, dp_op_val, rsp_valid, rsp_error},
                64'h0);
            chk("mid_reset_result", rsp_result, 64'h0);
            repeat (2) @(negedge clk);
            rst = 1'b1;
        end
        do_cmd(64'h5, 64'h3, 16'h0000, 4'd0, r, e, ok);
        chk("post_reset_result", {ok, e, r}, {1'b1, 1'b0, 64'h7});
        @(negedge clk);

        // Datapath never leaves IDLE: watchdog in START
        stub_hang = 1'b1;
        act0 = actcnt;
        do_cmd(64'h5, 64'h3, 16'h0000, 4'd0, r, e, ok);
        chk("wd_rsp_seen", ok, 1'b1);
        chk("wd_error", e, 1'b1);
        chk("wd_result", r, 64'h0);
        chk("wd_cycles", 64'(actcnt - act0), 64'd64);
        chk("wd_dp_quiet", {dp_start, dp_input_enable, dp_op_val}, 64'h0);
        @(negedge clk);
        chk("wd_error_cleared", {busy, rsp_valid, rsp_error}, 64'h0);
        stub_hang = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_op_sequencer.md
Name: dp_op_sequencer

Overview:
- Command-level controller for the 64-bit nibble-serial FSM datapath (8 compute states S0..S7, IDLE=8, INPUT=9, OUTPUT=10).
- Accepts one command per transaction: full-width operands, an op_val program and a program length.
- Sequences the datapath through start, 16-nibble operand load, the programmed op steps and a drain route into OUTPUT.
- Collects the 16 output nibbles into one result word and returns it with valid/ready.

Parameters:
- N, 64: operand/result width.
- N_width, 4: nibble width on the datapath port.
- PROG_DEPTH, 8: maximum op_val program steps.
- TIMEOUT, 64: watchdog limit in cycles.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_a  in  N  operand A
- cmd_b  in  N  operand B
- cmd_prog  in  2*PROG_DEPTH  op codes; step i is at [2i+1:2i]
- cmd_len  in  4  program length; values above PROG_DEPTH are clamped to PROG_DEPTH
- dp_start  out  1  to datapath start
- dp_input_enable  out  1  to datapath input_enable
- dp_a  out  N_width  to datapath a
- dp_b  out  N_width  to datapath b
- dp_op_val  out  2  to datapath op_val
- dp_state  in  4  datapath state_res
- dp_output_valid  in  1  datapath output_valid
- dp_out  in  N_width  datapath out
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  N  collected result
- rsp_error  out  1  watchdog fired for this result
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: rst low forces state IDLE and clears all latches, counters and outputs. cmd_ready=1 from the first cycle after release. Reset mid-operation aborts with no response; the datapath shares rst.
- Latches: A, B, prog and clamped len are captured in IDLE on cmd_valid&&cmd_ready. cmd_ready=1 only in IDLE.
- Default drives: dp_* outputs are 0 unless stated below.
- START:
  - dp_start=1.
  - Go to LOAD on the first cycle dp_state==9.
- LOAD:
  - dp_start=0, dp_input_enable=1.
  - dp_a=A[idx*N_width +: N_width] and dp_b likewise; idx counts 0..15, one per cycle.
  - After the idx==15 cycle go to RUN with pc=0.
  - On the following cycle the datapath is in S0.
- RUN:
  - Each cycle with dp_state in 0..7 and pc<len: dp_op_val=prog[pc], pc++.
  - When pc==len go to DRAIN. With len==0, RUN lasts 1 cycle and drives nothing.
- DRAIN: dp_op_val comes from a route table on dp_state:
  - S0->2, S1->2, S2->0, S3->0, S4->1, S5->0, S6->0, S7->0.
  - These steer every state to S4 and then to OUTPUT; worst case is 5 cycles, from S3.
- Capture:
  - In DRAIN or COLLECT, every cycle with dp_output_valid=1 writes result[cidx*N_width +: N_width]=dp_out and increments cidx.
  - Capture begins the first cycle dp_state==10, which also moves DRAIN to COLLECT.
  - After the cidx==15 capture go to RESP.
- RESP:
  - rsp_valid=1; rsp_result and rsp_error are held stable until rsp_ready.
  - On handshake go to IDLE and clear rsp_error.
  - rsp_valid never drops without rsp_ready.
- Watchdog:
  - The cycle counter clears on every sequencer state change.
  - In START, LOAD, RUN, DRAIN or COLLECT, reaching TIMEOUT forces RESP with rsp_error=1 and the partially collected result (uncaptured nibbles 0).
  - dp_* outputs drop to 0 on entry to RESP.
- Simultaneous events: cmd_valid outside IDLE is ignored. A command cannot be accepted in the same cycle as the rsp handshake; IDLE is required first.

Test Plan:
- A=0x5, B=0x3, len=0, rsp_ready=1 -> path S0,S4,OUTPUT; rsp_result=0x0000000000000007, rsp_error=0, busy back to 0 after handshake.
- Same A/B, len=1, prog[0]=3 -> path S0,S1,S5,S4,OUTPUT; rsp_result=0x5.
- Same A/B, cmd_len=15, prog all 0 -> clamped to 8 RUN steps holding S0, then drain; rsp_result=0x7; exactly 8 RUN op cycles observed.
- Hold rsp_ready=0 for 10 cycles after rsp_valid while pulsing cmd_valid -> rsp_valid, rsp_result and cmd_ready=0 stable; command not accepted; accepted after handshake plus IDLE.
- Assert rst for 2 cycles at LOAD idx=7 -> all outputs 0 and state IDLE; a following len=0 command returns 0x7.
- Datapath stub holds dp_state=8 -> after TIMEOUT cycles in START: rsp_valid=1, rsp_error=1, rsp_result=0.
